seg7_scan_driver: RTL and testbench

Time-multiplexed scan driver for the four-digit seven-segment display. It consumes the four digit bytes written by the processor into the display peripheral's register bank, and drives the active-low anode selects and cathode lines. It adds tear-free frame capture, per-digit decimal point and blanking, leading-zero suppression, and 16-step brightness PWM. It sits directly downstream of the bus-mapped display register bank, and its `SEG_SELECT`/`DEC_OUT` feed the board pins and the bank's read-back registers.

---
 rtl/seg7_pkg.sv | 48 ++++
 rtl/seg7_scan_driver_if.sv | 27 ++
 rtl/seg7_hex_decoder.sv | 14 +
 rtl/seg7_scan_driver.sv | 143 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, digit record type and hex-to-segment table for the
// four-digit seven-segment scan driver.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] SEL_NONE  = 4'hF;

    // Field positions inside a digit byte written by the processor.
    localparam int DP_BIT    = 4;
    localparam int BLANK_BIT = 7;

    // Snapshot entry: only the fields the display actually uses.
    typedef struct packed {
        logic       blank;
        logic       dp;
        logic [3:0] value;
    } digit_t;

    // Reset snapshot is a force-blanked digit so the panel stays dark
    // until the first real frame is captured.
    localparam digit_t DIGIT_RESET = '{blank: 1'b1, dp: 1'b0, value: 4'h0};

    // Active-low {g,f,e,d,c,b,a} pattern for a hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit/brightness inputs from the display register bank and the pin-side
// outputs of the scan driver.
interface seg7_scan_driver_if;

    logic [7:0] IN_A;
    logic [7:0] IN_B;
    logic [7:0] IN_C;
    logic [7:0] IN_D;
    logic [3:0] BRIGHTNESS;
    logic       LZB;
    logic [3:0] SEG_SELECT;
    logic [7:0] DEC_OUT;
    logic       FRAME;

    // Register bank side: supplies digits and settings, reads back outputs.
    modport master (
        output IN_A, IN_B, IN_C, IN_D, BRIGHTNESS, LZB,
        input  SEG_SELECT, DEC_OUT, FRAME
    );

    // Scan driver side.
    modport slave (
        input  IN_A, IN_B, IN_C, IN_D, BRIGHTNESS, LZB,
        output SEG_SELECT, DEC_OUT, FRAME
    );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex value to active-low seven-segment pattern.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg_n
);

    // Table lookup of the segment pattern for the current digit value.
    always_comb begin
        seg_n = hex_to_seg(value);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed four-digit seven-segment scan driver: prescaler, PWM
// phase and digit counters, per-frame snapshot of the digit bytes,
// leading-zero / force blanking and registered pin outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned TICK_DIV = 6250
) (
    input  logic              CLK,
    input  logic              RESET,
    seg7_scan_driver_if.slave bus
);

    logic [15:0] pre_r;
    logic [3:0]  phase_r;
    logic [1:0]  dig_r;
    digit_t      snap_r [4];
    logic [3:0]  sel_r;
    logic [7:0]  dec_r;
    logic        frame_r;

    logic        tick_s;
    logic        slot_end_s;
    logic        frame_end_s;
    digit_t      cur_s;
    logic [6:0]  seg_s;
    logic        on_s;
    logic        lzb_blank_s;
    logic [3:0]  sel_nxt_s;
    logic [7:0]  dec_nxt_s;
    logic        unused_bits_s;

    assign tick_s      = (pre_r == 16'(TICK_DIV - 32'd1));
    assign slot_end_s  = tick_s && (phase_r == 4'd15);
    assign frame_end_s = slot_end_s && (dig_r == 2'd3);

    // Bits 6:5 of each digit byte carry no meaning for the display.
    assign unused_bits_s = ^{bus.IN_A[6:5], bus.IN_B[6:5], bus.IN_C[6:5], bus.IN_D[6:5]};

    // Prescaler: counts CLK cycles per PWM tick.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pre_r <= 16'd0;
        end else if (tick_s) begin
            pre_r <= 16'd0;
        end else begin
            pre_r <= pre_r + 16'd1;
        end
    end

    // PWM phase within the slot and digit index; the digit moves on after phase 15.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            phase_r <= 4'd0;
            dig_r   <= 2'd0;
        end else if (tick_s) begin
            phase_r <= phase_r + 4'd1;
            dig_r   <= slot_end_s ? dig_r + 2'd1 : dig_r;
        end else begin
            phase_r <= phase_r;
            dig_r   <= dig_r;
        end
    end

    // Snapshot bank: all four digits are taken together at the end of digit 3's slot.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 4; i++) begin
                snap_r[i] <= DIGIT_RESET;
            end
        end else if (frame_end_s) begin
            snap_r[0] <= '{blank: bus.IN_A[BLANK_BIT], dp: bus.IN_A[DP_BIT], value: bus.IN_A[3:0]};
            snap_r[1] <= '{blank: bus.IN_B[BLANK_BIT], dp: bus.IN_B[DP_BIT], value: bus.IN_B[3:0]};
            snap_r[2] <= '{blank: bus.IN_C[BLANK_BIT], dp: bus.IN_C[DP_BIT], value: bus.IN_C[3:0]};
            snap_r[3] <= '{blank: bus.IN_D[BLANK_BIT], dp: bus.IN_D[DP_BIT], value: bus.IN_D[3:0]};
        end else begin
            snap_r <= snap_r;
        end
    end

    assign cur_s = snap_r[dig_r];

    seg7_hex_decoder u_hex_decoder (
        .value (cur_s.value),
        .seg_n (seg_s)
    );

    // Leading-zero suppression: a zero digit goes dark while every more
    // significant digit is also zero; a decimal point on a more significant
    // digit ends the suppression so readouts such as "0.00" keep their zeros.
    always_comb begin
        lzb_blank_s = 1'b0;
        case (dig_r)
            2'd0: lzb_blank_s = 1'b0;
            2'd1: lzb_blank_s = (snap_r[1].value == 4'h0)
                                && (snap_r[2].value == 4'h0) && !snap_r[2].dp
                                && (snap_r[3].value == 4'h0) && !snap_r[3].dp;
            2'd2: lzb_blank_s = (snap_r[2].value == 4'h0)
                                && (snap_r[3].value == 4'h0) && !snap_r[3].dp;
            2'd3: lzb_blank_s = (snap_r[3].value == 4'h0);
            default: lzb_blank_s = 1'b0;
        endcase
    end

    // Phase 0 is always dark so anodes never overlap across a slot change.
    assign on_s = (phase_r != 4'd0) && (phase_r <= bus.BRIGHTNESS);

    // Next pin values. A force-blanked digit drives neither anode nor
    // cathodes, which also keeps the panel dark before the first capture.
    always_comb begin
        sel_nxt_s = SEL_NONE;
        dec_nxt_s = SEG_BLANK;
        if (on_s && !cur_s.blank) begin
            sel_nxt_s = ~(4'b0001 << dig_r);
            if (bus.LZB && lzb_blank_s) begin
                dec_nxt_s = {~cur_s.dp, 7'h7F};
            end else begin
                dec_nxt_s = {~cur_s.dp, seg_s};
            end
        end else begin
            sel_nxt_s = SEL_NONE;
            dec_nxt_s = SEG_BLANK;
        end
    end

    // Output registers: pins and the frame pulse lag the counters by one cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sel_r   <= SEL_NONE;
            dec_r   <= SEG_BLANK;
            frame_r <= 1'b0;
        end else begin
            sel_r   <= sel_nxt_s;
            dec_r   <= dec_nxt_s;
            frame_r <= frame_end_s;
        end
    end

    assign bus.SEG_SELECT = sel_r;
    assign bus.DEC_OUT    = dec_r;
    assign bus.FRAME      = frame_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with TICK_DIV = 2.
module tb_seg7_scan_driver;

    localparam int TD        = 2;
    localparam int FRAME_CYC = 64 * TD;
    localparam logic [6:0] HEX_EXP [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E };

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.TICK_DIV(TD)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;      // rising edges since reset release
    logic [7:0] m_snap [4];
    logic [3:0] exp_sel;
    logic [7:0] exp_dec;
    logic       exp_frame;

    task automatic set_inputs(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        bus.IN_A = a; bus.IN_B = b; bus.IN_C = c; bus.IN_D = d;
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < 4; i++) m_snap[i] = 8'h80;
    endtask

    // Advance one clock; the reference model derives the expected pins from
    // the elapsed cycle count (tick = cyc/TD, phase = tick%16, digit = tick/16%4).
    task automatic step();
        logic [7:0] pin [4];
        int t, ph, d;
        logic blank;
        pin[0] = bus.IN_A; pin[1] = bus.IN_B; pin[2] = bus.IN_C; pin[3] = bus.IN_D;
        t  = cyc / TD;
        ph = t % 16;
        d  = (t / 16) % 4;
        exp_sel = 4'hF;
        exp_dec = 8'hFF;
        if (ph != 0 && ph <= int'(bus.BRIGHTNESS) && !m_snap[d][7]) begin
            exp_sel = 4'hF ^ (4'b0001 << d);
            blank = bus.LZB && (d != 0) && (m_snap[d][3:0] == 4'h0);
            for (int j = d + 1; j < 4; j++)
                if (m_snap[j][3:0] != 4'h0 || m_snap[j][4]) blank = 1'b0;
            exp_dec = {~m_snap[d][4], blank ? 7'h7F : HEX_EXP[m_snap[d][3:0]]};
        end
        exp_frame = ((cyc + 1) % FRAME_CYC) == 0;
        @(posedge CLK);
        cyc++;
        if (cyc % FRAME_CYC == 0)
            for (int i = 0; i < 4; i++) m_snap[i] = pin[i];
        #1;
    endtask

    task automatic test_reset();
        int dark_bad, frames, n_walk;
        logic [15:0] walk;
        logic [3:0] last;
        logic [7:0] seen [4];
        set_inputs(8'h04, 8'h03, 8'h02, 8'h01);
        bus.BRIGHTNESS = 4'd15; bus.LZB = 1'b0;
        #2 RESET = 1'b0;
        #1;
        checks++; if (bus.SEG_SELECT !== 4'hF) begin errors++; $display("FAIL reset_sel: got %h want F", bus.SEG_SELECT); end
        checks++; if (bus.DEC_OUT !== 8'hFF) begin errors++; $display("FAIL reset_dec: got %h want FF", bus.DEC_OUT); end
        checks++; if (bus.FRAME !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b want 0", bus.FRAME); end
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        model_reset();
        dark_bad = 0; frames = 0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            step();
            checks++; if (bus.SEG_SELECT !== exp_sel) begin errors++; $display("FAIL first_sel: got %h want %h cyc %0d", bus.SEG_SELECT, exp_sel, cyc); end
            checks++; if (bus.DEC_OUT !== exp_dec) begin errors++; $display("FAIL first_dec: got %h want %h cyc %0d", bus.DEC_OUT, exp_dec, cyc); end
            checks++; if (bus.FRAME !== exp_frame) begin errors++; $display("FAIL first_frame: got %b want %b cyc %0d", bus.FRAME, exp_frame, cyc); end
            if (bus.SEG_SELECT !== 4'hF || bus.DEC_OUT !== 8'hFF) dark_bad++;
            if (bus.FRAME === 1'b1) frames++;
        end
        checks++; if (dark_bad != 0) begin errors++; $display("FAIL first_dark: got %0d lit cycles want 0", dark_bad); end
        checks++; if (frames != 1) begin errors++; $display("FAIL first_frame_count: got %0d want 1", frames); end
        walk = 16'h0; n_walk = 0; last = 4'hF;
        for (int i = 0; i < 4; i++) seen[i] = 8'h00;
        for (int i = 0; i < FRAME_CYC; i++) begin
            step();
            if (bus.SEG_SELECT !== 4'hF) begin
                if (bus.SEG_SELECT !== last) begin walk = {walk[11:0], bus.SEG_SELECT}; n_walk++; end
                last = bus.SEG_SELECT;
                case (bus.SEG_SELECT)
                    4'hE: seen[0] = bus.DEC_OUT;
                    4'hD: seen[1] = bus.DEC_OUT;
                    4'hB: seen[2] = bus.DEC_OUT;
                    4'h7: seen[3] = bus.DEC_OUT;
                    default: seen[0] = 8'hxx;
                endcase
            end
        end
        checks++; if (walk !== 16'hEDB7 || n_walk != 4) begin errors++; $display("FAIL sel_walk: got %h (%0d steps) want EDB7 (4)", walk, n_walk); end
        checks++; if (seen[0] !== 8'h99) begin errors++; $display("FAIL dig0_dec: got %h want 99", seen[0]); end
        checks++; if (seen[1] !== 8'hB0) begin errors++; $display("FAIL dig1_dec: got %h want B0", seen[1]); end
        checks++; if (seen[2] !== 8'hA4) begin errors++; $display("FAIL dig2_dec: got %h want A4", seen[2]); end
        checks++; if (seen[3] !== 8'hF9) begin errors++; $display("FAIL dig3_dec: got %h want F9", seen[3]); end
    endtask

    task automatic test_brightness();
        int cnt [4];
        int dark, other;
        bus.BRIGHTNESS = 4'd4;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        dark = 0; other = 0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            step();
            case (bus.SEG_SELECT)
                4'hE: cnt[0]++;
                4'hD: cnt[1]++;
                4'hB: cnt[2]++;
                4'h7: cnt[3]++;
                4'hF: dark++;
                default: other++;
            endcase
        end
        for (int d = 0; d < 4; d++) begin
            checks++; if (cnt[d] != 8) begin errors++; $display("FAIL bright4_active dig%0d: got %0d want 8", d, cnt[d]); end
        end
        checks++; if (dark != 96 || other != 0) begin errors++; $display("FAIL bright4_dark: got %0d dark %0d bad want 96 0", dark, other); end
        bus.BRIGHTNESS = 4'd0;
        dark = 0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            step();
            if (bus.SEG_SELECT !== 4'hF || bus.DEC_OUT !== 8'hFF) dark++;
        end
        checks++; if (dark != 0) begin errors++; $display("FAIL bright0_lit: got %0d lit cycles want 0", dark); end
        bus.BRIGHTNESS = 4'd15;
    endtask

    task automatic test_lzb();
        logic [7:0] seen [4];
        set_inputs(8'h00, 8'h00, 8'h10, 8'h00);
        bus.LZB = 1'b1;
        do step(); while (cyc % FRAME_CYC != 0);
        for (int i = 0; i < 4; i++) seen[i] = 8'h00;
        for (int i = 0; i < FRAME_CYC; i++) begin
            step();
            case (bus.SEG_SELECT)
                4'hE: seen[0] = bus.DEC_OUT;
                4'hD: seen[1] = bus.DEC_OUT;
                4'hB: seen[2] = bus.DEC_OUT;
                4'h7: seen[3] = bus.DEC_OUT;
                default: ;
            endcase
        end
        checks++; if (seen[3] !== 8'hFF) begin errors++; $display("FAIL lzb_dig3: got %h want FF", seen[3]); end
        checks++; if (seen[2] !== 8'h7F) begin errors++; $display("FAIL lzb_dig2: got %h want 7F", seen[2]); end
        checks++; if (seen[1] !== 8'hC0) begin errors++; $display("FAIL lzb_dig1: got %h want C0", seen[1]); end
        checks++; if (seen[0] !== 8'hC0) begin errors++; $display("FAIL lzb_dig0: got %h want C0", seen[0]); end
        bus.LZB = 1'b0;
    endtask

    task automatic test_force_blank_tear();
        int bad, lit0, old_bad, old_seen, new_bad, new_seen;
        set_inputs(8'h04, 8'h85, 8'h02, 8'h01);
        do step(); while (cyc % FRAME_CYC != 0);
        bad = 0; lit0 = 0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            step();
            if ((((cyc - 1) / TD / 16) % 4) == 1 && (bus.SEG_SELECT !== 4'hF || bus.DEC_OUT !== 8'hFF)) bad++;
            if (bus.SEG_SELECT === 4'hD) bad++;
            if (bus.SEG_SELECT === 4'hE) lit0++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL force_blank_dig1: got %0d lit cycles want 0", bad); end
        checks++; if (lit0 != 30) begin errors++; $display("FAIL force_blank_dig0_lit: got %0d want 30", lit0); end
        repeat (8) step();
        bus.IN_A = 8'h07;
        old_bad = 0; old_seen = 0;
        do begin
            step();
            if (bus.SEG_SELECT === 4'hE) begin old_seen++; if (bus.DEC_OUT !== 8'h99) old_bad++; end
        end while (cyc % FRAME_CYC != 0);
        checks++; if (old_bad != 0 || old_seen == 0) begin errors++; $display("FAIL tear_old: got %0d wrong of %0d want 0 of >0", old_bad, old_seen); end
        new_bad = 0; new_seen = 0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            step();
            if (bus.SEG_SELECT === 4'hE) begin new_seen++; if (bus.DEC_OUT !== 8'hF8) new_bad++; end
        end
        checks++; if (new_bad != 0 || new_seen != 30) begin errors++; $display("FAIL tear_new: got %0d wrong of %0d want 0 of 30", new_bad, new_seen); end
    endtask

    task automatic test_async_reset();
        logic found;
        int dark_bad, frame_at;
        set_inputs(8'h04, 8'h03, 8'h02, 8'h01);
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_CYC && !found; i++) begin
            step();
            if (bus.SEG_SELECT === 4'hE) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL async_find_e: got no E select want E within %0d cycles", 2 * FRAME_CYC); end
        #2 RESET = 1'b0;
        #1;
        checks++; if (bus.SEG_SELECT !== 4'hF) begin errors++; $display("FAIL async_sel: got %h want F", bus.SEG_SELECT); end
        checks++; if (bus.DEC_OUT !== 8'hFF) begin errors++; $display("FAIL async_dec: got %h want FF", bus.DEC_OUT); end
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        model_reset();
        dark_bad = 0; frame_at = -1;
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            step();
            checks++; if (bus.SEG_SELECT !== exp_sel) begin errors++; $display("FAIL restart_sel: got %h want %h cyc %0d", bus.SEG_SELECT, exp_sel, cyc); end
            checks++; if (bus.DEC_OUT !== exp_dec) begin errors++; $display("FAIL restart_dec: got %h want %h cyc %0d", bus.DEC_OUT, exp_dec, cyc); end
            if (i < FRAME_CYC && (bus.SEG_SELECT !== 4'hF || bus.DEC_OUT !== 8'hFF)) dark_bad++;
            if (bus.FRAME === 1'b1 && frame_at < 0) frame_at = cyc;
        end
        checks++; if (dark_bad != 0) begin errors++; $display("FAIL restart_dark: got %0d lit cycles want 0", dark_bad); end
        checks++; if (frame_at != FRAME_CYC) begin errors++; $display("FAIL restart_frame_at: got %0d want %0d", frame_at, FRAME_CYC); end
    endtask

    task automatic test_decode_sweep();
        logic dp;
        logic [3:0] v;
        set_inputs(8'h00, 8'h00, 8'h00, 8'h00);
        bus.LZB = 1'b0; bus.BRIGHTNESS = 4'd15;
        for (int i = 0; i < 16; i++) begin
            v  = 4'(i);
            dp = 1'($urandom_range(0, 1));
            bus.IN_A = {3'b000, dp, v};
            do step(); while (cyc % FRAME_CYC != 0);
            repeat (4) step();
            checks++; if (bus.SEG_SELECT !== 4'hE) begin errors++; $display("FAIL sweep_sel %h: got %h want E", v, bus.SEG_SELECT); end
            checks++; if (bus.DEC_OUT !== {~dp, HEX_EXP[v]}) begin errors++; $display("FAIL sweep_dec %h dp%b: got %h want %h", v, dp, bus.DEC_OUT, {~dp, HEX_EXP[v]}); end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int i = 0; i < 8 * FRAME_CYC; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                b = 8'($urandom);
                if ($urandom_range(0, 3) != 0) b[7] = 1'b0;
                if ($urandom_range(0, 1) != 0) b[3:0] = 4'h0;
                case ($urandom_range(0, 3))
                    0: bus.IN_A = b;
                    1: bus.IN_B = b;
                    2: bus.IN_C = b;
                    default: bus.IN_D = b;
                endcase
            end
            if ($urandom_range(0, 31) == 0) bus.BRIGHTNESS = 4'($urandom);
            if ($urandom_range(0, 31) == 0) bus.LZB = 1'($urandom);
            step();
            checks++; if (bus.SEG_SELECT !== exp_sel) begin errors++; $display("FAIL rand_sel: got %h want %h cyc %0d", bus.SEG_SELECT, exp_sel, cyc); end
            checks++; if (bus.DEC_OUT !== exp_dec) begin errors++; $display("FAIL rand_dec: got %h want %h cyc %0d", bus.DEC_OUT, exp_dec, cyc); end
            checks++; if (bus.FRAME !== exp_frame) begin errors++; $display("FAIL rand_frame: got %b want %b cyc %0d", bus.FRAME, exp_frame, cyc); end
        end
    endtask

    initial begin
        set_inputs(8'h00, 8'h00, 8'h00, 8'h00);
        bus.BRIGHTNESS = 4'd15;
        bus.LZB = 1'b0;
        model_reset();
        test_reset();
        test_brightness();
        test_lzb();
        test_force_blank_tear();
        test_async_reset();
        test_decode_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
